mig_app_arbiter: RTL and testbench

Two-port arbiter and sequencer for the MIG 7-series DDR3 user (app) interface. It lets two requesters share one MIG controller, for example the UART command engine and the memory self-test engine. The block issues single-beat write and read commands with independent command and write-data handshakes. It routes each read return to the port that issued it through an in-order owner FIFO. It sits in the `ui_clk` domain directly in front of `xlnx_mig_7_ddr3`.

---
 rtl/mig_arb_pkg.sv | 16 +
 rtl/mig_arb_owner_fifo.sv | 57 +++++
 rtl/mig_app_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mig_app_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_arb_pkg.sv
// rtl/mig_arb_pkg.sv - shared command codes, FSM states and owner id type for the MIG app arbiter
package mig_arb_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Which requester issued a read; port 0 or port 1.
  typedef logic owner_t;

endpackage

// File: rtl/mig_arb_owner_fifo.sv
// rtl/mig_arb_owner_fifo.sv - in-order FIFO of read owner ids, one entry per outstanding read
module mig_arb_owner_fifo
  import mig_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  owner_t push_id_i,
  input  logic   pop_i,
  output owner_t pop_id_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = $clog2(DEPTH);

  owner_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o   = (count_q == (PW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign pop_id_o = mem_q[rd_ptr_q];

  // A push into a full FIFO or a pop from an empty one is dropped; both
  // in the same cycle leave the count unchanged.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

  // Pointers and occupancy; reset flushes all outstanding owners.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mig_app_arbiter.sv
// rtl/mig_app_arbiter.sv - two-port arbiter/sequencer for the MIG 7-series app interface; MIG_ARB_RR_EN selects round-robin
module mig_app_arbiter
  import mig_arb_pkg::*;
#(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 256,
  parameter int RD_DEPTH = 4
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic                calib_done,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  output logic                p0_ack,
  output logic                p0_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  output logic                p1_ack,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                rd_err
);

  state_t              state_q, state_d;
  owner_t              gnt_q, gnt_d;
  logic                app_en_q, app_en_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rd_err_q;

  logic                fifo_push;
  logic                fifo_full;
  logic                fifo_empty;
  owner_t              fifo_pop_id;
  logic                elig0, elig1;
  logic                pick1;
  logic                sel_we;

  // Reads need a free owner slot; writes never return data.
  assign elig0 = p0_req & (p0_we | ~fifo_full);
  assign elig1 = p1_req & (p1_we | ~fifo_full);

`ifdef MIG_ARB_RR_EN
  owner_t last_q;

  // Last port granted; starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst)    last_q <= 1'b1;
    else if (state_q == ACK) last_q <= gnt_q;
  end

  assign pick1 = elig1 & (~elig0 | ~last_q);
`else
  assign pick1 = elig1 & ~elig0;
`endif

  assign sel_we = pick1 ? p1_we : p0_we;

  // Grant, then wait for the command and write-data handshakes independently.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    app_en_d  = app_en_q;
    wren_d    = wren_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    wdata_d   = wdata_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (calib_done & (elig0 | elig1)) begin
          gnt_d    = pick1;
          addr_d   = pick1 ? p1_addr : p0_addr;
          wdata_d  = pick1 ? p1_wdata : p0_wdata;
          cmd_d    = sel_we ? CMD_WRITE : CMD_READ;
          app_en_d = 1'b1;
          wren_d   = sel_we;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (app_en_q & app_rdy) begin
          app_en_d  = 1'b0;
          fifo_push = (cmd_q == CMD_READ);
        end
        if (wren_q & app_wdf_rdy) wren_d = 1'b0;
        if ((~app_en_q | app_rdy) & (~wren_q | app_wdf_rdy)) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command-side registers; reset drops any command in flight.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      app_en_q <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      cmd_q    <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      app_en_q <= app_en_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  mig_arb_owner_fifo #(
    .DEPTH (RD_DEPTH)
  ) u_owner_fifo (
    .clk_i     (ui_clk),
    .rst_i     (ui_clk_sync_rst),
    .push_i    (fifo_push),
    .push_id_i (gnt_q),
    .pop_i     (app_rd_data_valid),
    .pop_id_o  (fifo_pop_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Route each read return to its owner; data with no owner is an error.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      if (app_rd_data_valid) begin
        if (fifo_empty) begin
          rd_err_q <= 1'b1;
        end else begin
          rdata_q   <= app_rd_data;
          rvalid0_q <= ~fifo_pop_id;
          rvalid1_q <= fifo_pop_id;
        end
      end
    end
  end

  assign app_addr     = addr_q;
  assign app_cmd      = cmd_q;
  assign app_en       = app_en_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = 1'b1;
  assign app_wdf_mask = '0;
  assign p0_ack       = ack0_q;
  assign p1_ack       = ack1_q;
  assign p0_rvalid    = rvalid0_q;
  assign p1_rvalid    = rvalid1_q;
  assign p0_rdata     = rdata_q;
  assign p1_rdata     = rdata_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_mig_app_arbiter.sv
// tb/tb_mig_app_arbiter.sv - self-checking bench for mig_app_arbiter with a transaction-level reference model
module tb_mig_app_arbiter;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int D  = 4;

  logic            ui_clk = 1'b0;
  logic            rst = 1'b1;
  logic            calib_done = 1'b0;
  logic            p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0]   p0_addr = '0, p1_addr = '0;
  logic [DW-1:0]   p0_wdata = '0, p1_wdata = '0;
  logic            p0_ack, p1_ack, p0_rvalid, p1_rvalid;
  logic [DW-1:0]   p0_rdata, p1_rdata;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en, app_wdf_wren, app_wdf_end;
  logic [DW-1:0]   app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask;
  logic            app_rdy = 1'b0, app_wdf_rdy = 1'b0;
  logic [DW-1:0]   app_rd_data = '0;
  logic            app_rd_data_valid = 1'b0;
  logic            rd_err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 ui_clk = ~ui_clk;

  mig_app_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_DEPTH(D)) dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(rst), .calib_done(calib_done),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .rd_err(rd_err)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  // Reference model: phase 0 waiting, 1 command in flight, 2 acknowledging.
  int            m_phase;
  bit            m_en, m_wren, m_gnt, m_ack0, m_ack1, m_rv0, m_rv1, m_err, m_last;
  logic [AW-1:0] m_addr;
  logic [2:0]    m_cmd;
  logic [DW-1:0] m_wdata, m_rdata;
  bit            m_q[$];

  always @(posedge ui_clk) begin : model
    int sz;
    bit e0, e1, win, we, own;
    if (rst) begin
      m_phase = 0; m_en = 0; m_wren = 0; m_gnt = 0; m_ack0 = 0; m_ack1 = 0;
      m_rv0 = 0; m_rv1 = 0; m_err = 0; m_last = 1;
      m_addr = '0; m_cmd = '0; m_wdata = '0; m_rdata = '0;
      m_q.delete();
    end else begin
      sz = m_q.size();
      m_ack0 = 0; m_ack1 = 0; m_rv0 = 0; m_rv1 = 0;
      if (app_rd_data_valid) begin
        if (sz == 0) m_err = 1;
        else begin
          own = m_q.pop_front();
          m_rdata = app_rd_data;
          m_rv0 = !own;
          m_rv1 = own;
        end
      end
      case (m_phase)
        0: begin
          e0 = p0_req && (p0_we || sz < D);
          e1 = p1_req && (p1_we || sz < D);
          if (calib_done && (e0 || e1)) begin
`ifdef MIG_ARB_RR_EN
            win = (e0 && e1) ? !m_last : e1;
`else
            win = !e0;
`endif
            we      = win ? p1_we : p0_we;
            m_gnt   = win;
            m_addr  = win ? p1_addr : p0_addr;
            m_wdata = win ? p1_wdata : p0_wdata;
            m_cmd   = we ? 3'b000 : 3'b001;
            m_en    = 1;
            m_wren  = we;
            m_phase = 1;
          end
        end
        1: begin
          if (m_en && app_rdy) begin
            m_en = 0;
            if (m_cmd == 3'b001) m_q.push_back(m_gnt);
          end
          if (m_wren && app_wdf_rdy) m_wren = 0;
          if (!m_en && !m_wren) begin
            m_ack0 = !m_gnt;
            m_ack1 = m_gnt;
            m_phase = 2;
          end
        end
        default: begin
          m_last = m_gnt;
          m_phase = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge ui_clk) begin
    if (chk_en) begin
      check("ctrl", DW'({app_en, app_wdf_wren, p0_ack, p1_ack, p0_rvalid, p1_rvalid, rd_err}),
            DW'({m_en, m_wren, m_ack0, m_ack1, m_rv0, m_rv1, m_err}));
      check("cmd", DW'({app_addr, app_cmd}), DW'({m_addr, m_cmd}));
      check("wdata", app_wdf_data, m_wdata);
      check("rdata0", p0_rdata, m_rdata);
      check("rdata1", p1_rdata, m_rdata);
      check("tieoffs", DW'({app_wdf_end, app_wdf_mask}), DW'({1'b1, 32'h0}));
    end
  end

  task automatic wait_ack(input bit port, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (port ? p1_ack : p0_ack) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_req(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    if (port) begin p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1; end
    else      begin p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1; end
    wait_ack(port, ok);
    check("req_ack_timeout", DW'(ok), DW'(1));
    if (port) p1_req = 0; else p0_req = 0;
  endtask

  task automatic ret(input logic [DW-1:0] d);
    app_rd_data = d;
    app_rd_data_valid = 1;
    tick();
    app_rd_data_valid = 0;
  endtask

  initial begin
    int cnt;
    bit ok;
    logic [3:0] seq;
    logic [DW-1:0] wd;
    logic [DW-1:0] rv [4];
    logic [1:0] own_exp [4];

    repeat (3) tick();
    chk_en = 1;
    rst = 0;
    tick();
    check("rst_outputs", DW'({app_en, app_wdf_wren, p0_ack, p1_ack, rd_err, app_addr}), '0);

    // Calibration gating, then port 0 wins the first tie.
    app_rdy = 1; app_wdf_rdy = 1;
    p0_we = 0; p0_addr = 28'h10; p0_req = 1;
    p1_we = 0; p1_addr = 28'h20; p1_req = 1;
    cnt = 0;
    repeat (20) begin tick(); if (app_en) cnt++; end
    check("calib_block", DW'(cnt), DW'(0));
    calib_done = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (p0_ack || p1_ack) begin ok = 1; break; end
    end
    check("first_ack", DW'({ok, p0_ack, p1_ack}), DW'(3'b110));
    p0_req = 0;
    wait_ack(1, ok);
    check("second_ack_p1", DW'(ok), DW'(1));
    p1_req = 0;
    ret(256'h1111);
    check("ret_a", DW'({p0_rvalid, p1_rvalid, p0_rdata[15:0]}), DW'({2'b10, 16'h1111}));
    ret(256'h2222);
    check("ret_b", DW'({p0_rvalid, p1_rvalid, p1_rdata[15:0]}), DW'({2'b01, 16'h2222}));

    // Both ports request reads continuously.
    p0_addr = 28'h100; p1_addr = 28'h200;
    p0_req = 1; p1_req = 1;
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (p0_ack || p1_ack) begin ok = 1; break; end
      end
      check("arb_ack_timeout", DW'(ok), DW'(1));
      seq[k] = p1_ack;
      if (k == 3) begin p0_req = 0; p1_req = 0; end
      ret(DW'(k + 16'h50));
    end
`ifdef MIG_ARB_RR_EN
    check("arb_seq", DW'(seq), DW'(4'b1010));
`else
    check("arb_seq", DW'(seq), DW'(4'b0000));
`endif
    repeat (3) tick();

    // Write with the write-data channel lagging the command channel.
    wd = 256'hCAFEBABE_12345678_AA55AA55_55AA55AA;
    app_rdy = 1; app_wdf_rdy = 0;
    p0_we = 1; p0_addr = '0; p0_wdata = wd; p0_req = 1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (app_en) begin ok = 1; break; end end
    check("wr_grant", DW'({ok, app_wdf_wren, app_cmd}), DW'({1'b1, 1'b1, 3'b000}));
    check("wr_data", app_wdf_data, wd);
    tick();
    check("wr_en_clear", DW'({app_en, app_wdf_wren, p0_ack}), DW'(3'b010));
    tick(); tick();
    check("wr_wren_hold", DW'({app_wdf_wren, p0_ack}), DW'(2'b10));
    app_wdf_rdy = 1;
    tick();
    check("wr_done_ack", DW'({app_wdf_wren, p0_ack}), DW'(2'b01));
    p0_req = 0;
    p0_we = 0;
    repeat (2) tick();

    // Fill the owner FIFO, a fifth read must stall.
    do_req(0, 0, 28'h400, '0);
    do_req(1, 0, 28'h410, '0);
    do_req(1, 0, 28'h420, '0);
    do_req(0, 0, 28'h430, '0);
    p1_we = 0; p1_addr = 28'h440; p1_req = 1;
    cnt = 0;
    repeat (20) begin tick(); if (app_en) cnt++; end
    check("full_block", DW'(cnt), DW'(0));
    p1_req = 0;
    tick();
    rv[0] = 256'hA0; rv[1] = 256'hB1; rv[2] = 256'hC2; rv[3] = 256'hD3;
    own_exp[0] = 2'b10; own_exp[1] = 2'b01; own_exp[2] = 2'b01; own_exp[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      ret(rv[k]);
      check("fifo_order", DW'({p0_rvalid, p1_rvalid}), DW'(own_exp[k]));
      check("fifo_data", p0_rdata, rv[k]);
    end
    tick();

    // Read data with nothing outstanding.
    check("err_clear", DW'(rd_err), DW'(0));
    ret(256'hDEAD);
    check("err_set", DW'({rd_err, p0_rvalid, p1_rvalid}), DW'(3'b100));
    repeat (3) tick();
    check("err_sticky", DW'(rd_err), DW'(1));

    // Reset while a read command is stalled.
    app_rdy = 0;
    p0_we = 0; p0_addr = 28'h300; p0_req = 1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (app_en) begin ok = 1; break; end end
    check("rst_mid_grant", DW'(ok), DW'(1));
    rst = 1;
    tick();
    check("rst_mid_en", DW'({app_en, rd_err}), DW'(2'b00));
    rst = 0;
    p0_req = 0;
    app_rdy = 1;
    cnt = 0;
    repeat (6) begin tick(); if (p0_ack || p1_ack) cnt++; end
    check("rst_no_ack", DW'(cnt), DW'(0));
    ret(256'hBEEF);
    check("rst_fifo_empty", DW'({rd_err, p0_rvalid}), DW'(2'b10));
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
